// File: rtl/ahb_burst_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ahb_arb_pkg
// Shared definitions for the burst-aware round-robin output-stage arbiter:
//   - HTRANS / HBURST encodings
//   - arbiter state enum
//   - beats_m1(): HBURST -> (beats - 1) for defined-length bursts, else 0
// -----------------------------------------------------------------------------
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    ST_NONE   = 3'd0,
    ST_SINGLE = 3'd1,
    ST_BURST  = 3'd2,
    ST_UNDEF  = 3'd3,
    ST_LOCK   = 3'd4
  } arb_state_e;

  // Remaining beats after the NONSEQ beat; zero for SINGLE and INCR.
  function automatic logic [3:0] beats_m1(input logic [2:0] hburst);
    logic [3:0] n;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  n = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  n = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
      default:                      n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_burst_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// ahb_burst_rr_arbiter_if
// Bundle between the input stages / output-stage mux and the arbiter.
//   req_port     : per-port request (held_tran & sel)
//   HREADYM      : muxed HREADY, 1 = address phase accepted
//   HSELM        : slave select of the muxed port
//   HTRANSM      : HTRANS of the muxed port
//   HBURSTM      : HBURST of the muxed port
//   HMASTLOCKM   : HMASTLOCK of the muxed port (HSEL-qualified)
//   addr_in_port : granted port index (registered, from arbiter)
//   no_port      : 1 = nothing granted, stage drives idle (registered)
// Modports: master = bus side driving requests/controls, slave = arbiter.
// -----------------------------------------------------------------------------
interface ahb_burst_rr_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
);

  logic [NUM_PORTS-1:0] req_port;
  logic                 HREADYM;
  logic                 HSELM;
  logic [1:0]           HTRANSM;
  logic [2:0]           HBURSTM;
  logic                 HMASTLOCKM;
  logic [PORT_W-1:0]    addr_in_port;
  logic                 no_port;

  modport master (
    output req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port
  );

  modport slave (
    input  req_port, HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port
  );

endinterface

// File: rtl/ahb_burst_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. Scans from i_ptr+1 upward with
// wrap; the port at i_ptr itself is checked last (lowest priority).
//   i_req     : request vector
//   i_ptr     : last granted port
//   o_winner  : first requesting port after i_ptr (0 when none)
//   o_any_req : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PORT_W-1:0]    i_ptr,
  output logic [PORT_W-1:0]    o_winner,
  output logic                 o_any_req
);

  logic [PORT_W-1:0] w_idx;
  logic              w_hit;
  logic              w_found;

  // Rotating first-one search; offset NUM_PORTS lands back on i_ptr.
  always_comb begin
    w_idx    = {PORT_W{1'b0}};
    w_hit    = 1'b0;
    w_found  = 1'b0;
    o_winner = {PORT_W{1'b0}};
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx    = PORT_W'((int'(i_ptr) + k) % NUM_PORTS);
      w_hit    = ~w_found & i_req[w_idx];
      o_winner = w_hit ? w_idx : o_winner;
      w_found  = w_found | w_hit;
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/ahb_burst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_burst_rr_arbiter
// Round-robin, burst-aware arbiter for one bus-matrix output stage. Keeps the
// owner across defined-length bursts, undefined-length (INCR) bursts and
// locked sequences; re-arbitrates otherwise. All state moves only on accepted
// edges (HREADYM = 1).
//   HCLK    : bus clock
//   HRESETn : asynchronous active-low reset
//   bus     : ahb_burst_rr_arbiter_if.slave (requests, muxed controls in;
//             registered addr_in_port / no_port out)
// -----------------------------------------------------------------------------
module ahb_burst_rr_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  ahb_burst_rr_arbiter_if.slave  bus
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [PORT_W-1:0] r_ptr;
  logic [PORT_W-1:0] w_ptr_nxt;
  logic [PORT_W-1:0] r_addr_in_port;
  logic [PORT_W-1:0] w_addr_nxt;
  logic              r_no_port;
  logic              w_no_port_nxt;

  logic [PORT_W-1:0] w_winner;
  logic              w_any_req;
  logic              w_owned;
  logic              w_nonseq;
  logic              w_seq;
  logic              w_busy;
  logic [3:0]        w_bm1;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_pick (
    .i_req     (bus.req_port),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  // With no_port=1 the stage drives idle, so the muxed controls carry no
  // owner transfer; only an owned stage can start or continue a burst.
  assign w_owned  = ~r_no_port;
  assign w_nonseq = bus.HSELM & (bus.HTRANSM == HTRANS_NONSEQ);
  assign w_seq    = bus.HSELM & (bus.HTRANSM == HTRANS_SEQ);
  assign w_busy   = bus.HSELM & (bus.HTRANSM == HTRANS_BUSY);
  assign w_bm1    = beats_m1(bus.HBURSTM);

  // Beat counter: loads on NONSEQ, counts SEQ down to 0 (never wraps),
  // holds on BUSY, clears on IDLE / deselect. Also tracks while locked.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if (!w_owned) begin
      w_cnt_nxt = 4'd0;
    end else if (w_nonseq) begin
      w_cnt_nxt = w_bm1;
    end else if (w_seq && (r_cnt != 4'd0)) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end else if (w_busy) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = 4'd0;
    end
  end

  // Next state and grant: hold the owner while locked or inside a burst,
  // otherwise re-arbitrate (current owner is the last candidate).
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr_in_port;
    w_no_port_nxt = r_no_port;
    w_ptr_nxt     = r_ptr;
    if (w_owned && bus.HMASTLOCKM) begin
      w_state_nxt = ST_LOCK;
    end else if (w_owned && w_nonseq && (w_bm1 != 4'd0)) begin
      w_state_nxt = ST_BURST;
    end else if (w_owned && w_nonseq && (bus.HBURSTM == HBURST_INCR)) begin
      w_state_nxt = ST_UNDEF;
    end else if (w_owned && (w_seq || w_busy) && (w_cnt_nxt != 4'd0)) begin
      // Covers SEQ/BUSY mid-burst and leaving LOCK with beats outstanding.
      w_state_nxt = ST_BURST;
    end else if (w_owned && (w_seq || w_busy) && (r_state == ST_UNDEF)) begin
      // INCR bursts run with count 0 and end only on IDLE / deselect.
      w_state_nxt = ST_UNDEF;
    end else begin
      if (w_any_req) begin
        w_addr_nxt    = w_winner;
        w_no_port_nxt = 1'b0;
        w_ptr_nxt     = w_winner;
        w_state_nxt   = ST_SINGLE;
      end else begin
        w_no_port_nxt = 1'b1;
        w_state_nxt   = ST_NONE;
      end
    end
  end

  // State register; frozen during wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state        <= ST_NONE;
      r_cnt          <= 4'd0;
      r_ptr          <= PORT_W'(NUM_PORTS - 1);
      r_addr_in_port <= {PORT_W{1'b0}};
      r_no_port      <= 1'b1;
    end else if (bus.HREADYM) begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_ptr          <= w_ptr_nxt;
      r_addr_in_port <= w_addr_nxt;
      r_no_port      <= w_no_port_nxt;
    end
  end

  assign bus.addr_in_port = r_addr_in_port;
  assign bus.no_port      = r_no_port;

endmodule

// File: tb/tb_ahb_burst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_burst_rr_arbiter
// Directed-vector bench for ahb_burst_rr_arbiter (NUM_PORTS=4). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_ahb_burst_rr_arbiter;
  import ahb_arb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [1:0] incr4_trans [6];
  logic [1:0] incr4_exp   [6];
  logic [1:0] wrap8_trans [4];
  logic [1:0] wrap8_exp   [4];
  logic [1:0] rr_exp      [5];
  logic       lock_sel    [5];
  logic [1:0] lock_trans  [5];

  ahb_burst_rr_arbiter_if #(.NUM_PORTS(4), .PORT_W(2)) bus_if ();

  ahb_burst_rr_arbiter #(
    .NUM_PORTS (4),
    .PORT_W    (2)
  ) u_dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_if)
  );

  // 10-unit bus clock.
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic exp_np, input logic [1:0] exp_addr);
    check_eq({tag, "_no_port"}, 32'(bus_if.no_port), 32'(exp_np));
    check_eq({tag, "_addr"}, 32'(bus_if.addr_in_port), 32'(exp_addr));
  endtask

  task automatic drive(input logic [3:0] req, input logic sel, input logic [1:0] trans,
                       input logic [2:0] burst, input logic lock);
    bus_if.req_port   = req;
    bus_if.HREADYM    = 1'b1;
    bus_if.HSELM      = sel;
    bus_if.HTRANSM    = trans;
    bus_if.HBURSTM    = burst;
    bus_if.HMASTLOCKM = lock;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Reset pulse placed between edges; reset values must appear at once.
  task automatic pulse_reset(input string tag);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_grant(tag, 1'b1, 2'd0);
    HRESETn = 1'b1;
  endtask

  initial begin
    incr4_trans = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ};
    incr4_exp   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3};
    wrap8_trans = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE};
    wrap8_exp   = '{2'd0, 2'd0, 2'd0, 2'd2};
    rr_exp      = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    lock_sel    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    lock_trans  = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_NONSEQ, HTRANS_SEQ};

    // Reset and first grant
    drive(4'b0000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    pulse_reset("reset");
    tick();
    chk_grant("idle_no_req", 1'b1, 2'd0);
    drive(4'b0100, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("first_grant", 1'b0, 2'd2);
    drive(4'b0000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("release_hold_addr", 1'b1, 2'd2);

    // Round robin with singles
    pulse_reset("rr_reset");
    drive(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grant($sformatf("rr%0d", i), 1'b0, rr_exp[i]);
    end

    // Wait states freeze grant even when requests drop
    bus_if.HREADYM  = 1'b0;
    bus_if.req_port = 4'b0000;
    bus_if.HTRANSM  = HTRANS_IDLE;
    tick();
    chk_grant("wait_freeze0", 1'b0, 2'd0);
    tick();
    chk_grant("wait_freeze1", 1'b0, 2'd0);
    drive(4'b0000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("wait_release", 1'b1, 2'd0);

    // INCR4 from port 1 with two BUSY cycles, port 3 waiting
    pulse_reset("incr4_reset");
    drive(4'b1010, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("incr4_grant", 1'b0, 2'd1);
    for (int i = 0; i < 6; i++) begin
      drive(4'b1010, 1'b1, incr4_trans[i], HBURST_INCR4, 1'b0);
      tick();
      chk_grant($sformatf("incr4_step%0d", i), 1'b0, incr4_exp[i]);
    end
    drive(4'b1010, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("incr4_after", 1'b0, 2'd1);

    // WRAP8 from port 0 terminated by IDLE after beat 3
    pulse_reset("early_reset");
    drive(4'b0001, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("early_grant", 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0101, 1'b1, wrap8_trans[i], HBURST_WRAP8, 1'b0);
      tick();
      chk_grant($sformatf("early_step%0d", i), 1'b0, wrap8_exp[i]);
    end
    // A stray SEQ now must not resume the old burst count.
    drive(4'b0101, 1'b1, HTRANS_SEQ, HBURST_WRAP8, 1'b0);
    tick();
    chk_grant("early_cnt_cleared", 1'b0, 2'd0);

    // Port 2 locked across two INCR bursts, ports 0/1 requesting
    pulse_reset("lock_reset");
    drive(4'b0100, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("lock_grant", 1'b0, 2'd2);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0111, lock_sel[i], lock_trans[i], HBURST_INCR, 1'b1);
      tick();
      chk_grant($sformatf("lock_step%0d", i), 1'b0, 2'd2);
    end
    drive(4'b0111, 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    bus_if.HREADYM = 1'b0;
    tick();
    chk_grant("unlock_wait", 1'b0, 2'd2);
    bus_if.HREADYM = 1'b1;
    tick();
    chk_grant("unlock_rearb", 1'b0, 2'd0);

    // Reset in the middle of an INCR16 burst
    pulse_reset("midrst_reset0");
    drive(4'b0010, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("midrst_grant", 1'b0, 2'd1);
    drive(4'b0010, 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0);
      tick();
    end
    chk_grant("midrst_in_burst", 1'b0, 2'd1);
    pulse_reset("midrst_immediate");
    drive(4'b1000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
    tick();
    chk_grant("midrst_regrant", 1'b0, 2'd3);
    drive(4'b1001, 1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0);
    tick();
    chk_grant("midrst_cnt_cleared", 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_burst_rr_arbiter.md
# ahb_burst_rr_arbiter

Round-robin, burst-aware arbiter for one bus-matrix output stage. It chooses which of `NUM_PORTS` input stages drives the shared slave address/control bus and reports the choice as a registered port index plus a no-port flag. It replaces fixed-priority selection for output stages with more than one connected input. It never breaks a defined-length burst or a locked sequence.

## Interface
- `NUM_PORTS`, default 4, is the number of requesting input stages. Legal range is 2–16.
- `PORT_W`, default 2, is the index width and equals clog2(`NUM_PORTS`).
- `HCLK`  in  1  Bus clock.
- `HRESETn`  in  1  Reset. Asynchronous, active-low.
- `req_port`  in  `NUM_PORTS`  Per-port request, equal to held_tran & sel from each input stage.
- `HREADYM`  in  1  Muxed HREADY of this output stage. 1 = the address phase is accepted this cycle.
- `HSELM`  in  1  Slave select of the currently muxed port.
- `HTRANSM`  in  2  HTRANS of the muxed port.
- `HBURSTM`  in  3  HBURST of the muxed port.
- `HMASTLOCKM`  in  1  HMASTLOCK of the muxed port, already qualified by HSEL.
- `addr_in_port`  out  `PORT_W`  Granted port index. Registered.
- `no_port`  out  1  1 = no port granted. The output stage then drives idle. Registered.

## Operation
- **Accepted edge.** An accepted edge is a rising `HCLK` edge with `HREADYM`=1. All state changes occur only on accepted edges.
- **State machine.**
  - States are NONE, SINGLE, BURST, UNDEF, LOCK.
  - NONE is the reset state. In NONE, `no_port`=1.
- **Re-arbitration condition (rearb), evaluated at each accepted edge.**
  - rearb is 1 in NONE and in SINGLE.
  - rearb is 1 in BURST when the last SEQ beat is accepted (count==1 and `HTRANSM`=SEQ).
  - rearb is 1 in BURST or UNDEF on early termination: `HTRANSM`=IDLE, or `HSELM`=0.
  - rearb is never 1 in LOCK.
- **Winner selection.**
  - The search starts at ptr+1 and wraps modulo `NUM_PORTS`. The first set bit of `req_port` wins.
  - The winner is loaded into `addr_in_port`, `no_port` is set to 0, and ptr is set to the winner.
  - If no bit is set: `no_port` is set to 1, `addr_in_port` holds its value, and ptr is unchanged.
  - The current owner is an eligible candidate. Its priority is lowest.
- **Next state, applied at an accepted edge, first match wins.**
  1. `HMASTLOCKM`=1 → LOCK. LOCK holds the owner while `HMASTLOCKM`=1, and exits through rule 2–5 classification when `HMASTLOCKM`=0 at an accepted edge.
  2. NONSEQ with `HSELM`=1 and `HBURSTM` in {WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} → BURST. The beat counter is loaded with beats−1, i.e. 3, 7 or 15.
  3. NONSEQ with `HSELM`=1 and `HBURSTM`=INCR → UNDEF. The owner is held until early termination.
  4. SEQ in BURST → decrement the counter. If the count reaches 0, rearb applies.
  5. BUSY → hold the state and the counter.
  6. Otherwise → SINGLE, or NONE if `no_port`=1.
- **NONSEQ inside BURST or UNDEF.** This is an early termination plus a new burst start from the same owner. The counter is reloaded and ownership is kept. The owner already holds the address phase.
- **Counter.** The counter is 4 bits. It never wraps below 0. A SEQ seen at count 0 is treated as SINGLE.
- **Locking.** The counter keeps tracking during LOCK. After unlock, if the counter is nonzero the state is BURST.
- **Illegal `HBURSTM`.** Values outside the encoded set cannot occur with a 3-bit field, so none need handling.

## Timing
- **Reset values.** `no_port`=1, `addr_in_port`=0, ptr=`NUM_PORTS`−1 so that port 0 wins first, counter=0, state=NONE.
- **Grant latency.** A request seen at accepted edge N appears on `addr_in_port` and `no_port` after edge N. That is one cycle, valid for the next address phase.
- **Wait states.** With `HREADYM`=0, the outputs, the counter and ptr are frozen. A request that drops during wait states does not release the grant until the next accepted edge.
- **Simultaneous requests.** Round-robin order applies. With all requesting and no bursts, grants rotate 0, 1, 2, 3, 0, ...
- **Asynchronous reset.** Assertion returns all registers to their reset values immediately, mid-burst or mid-lock. There is no memory of the prior owner.

## Structure
- **Shared package `ahb_arb_pkg`.**
  - Constants for the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HBURST encodings (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16).
  - The state enum.
  - A beats-minus-one function mapping HBURST to a 4-bit count.
- **Sub-module `rr_pick`.** A combinational winner search taking req, ptr, winner and any_req. It is reused by other multi-port output stages.

## Test plan
- **Reset.** Drive `HRESETn`=0. Expect `no_port`=1 and `addr_in_port`=0. Release, then raise `req_port`=4'b0100 → after the next accepted edge, expect `addr_in_port`=2 and `no_port`=0.
- **Round-robin.** Hold `req_port`=4'b1111 with single NONSEQ transfers and `HREADYM`=1. Expect grants 0, 1, 2, 3, 0 on consecutive cycles.
- **INCR4 burst.** Port 1 issues INCR4 with 2 BUSY cycles inserted, while port 3 requests. Expect `addr_in_port`=1 through 4 accepted beats, then 3 on the edge after the fourth beat.
- **Early termination.** Port 0 issues WRAP8 and drives IDLE after beat 3. Expect a switch to the requesting port 2 at that edge and the counter cleared.
- **Lock.** Port 2 asserts `HMASTLOCKM` across two INCR bursts with `HSELM` dropping between them, while ports 0 and 1 request. Expect the grant to stay at 2 until an accepted edge with `HMASTLOCKM`=0.
- **Mid-burst reset.** Assert reset during INCR16 beat 5. Expect immediate reset values. After release with `req_port`=4'b1000, expect a grant to 3.
